// File: rtl/bip_pkg.sv
// Shared encodings for the BIP controller: FSM states, opcodes, acc source selects.
package bip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // Instructions whose operand is a data-memory address that must be read.
  function automatic logic reads_mem(input logic [4:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode-to-control decode. DECODE-phase strobes use the live
// instruction word; EXEC-phase controls use the latched IR opcode.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NB_OPC = 5
) (
  input  logic              i_decode,
  input  logic              i_exec,
  input  logic [NB_OPC-1:0] i_opc_dec,
  input  logic [NB_OPC-1:0] i_opc_ex,
  output logic              o_rd_ram,
  output logic              o_wr_ram,
  output logic              o_wr_acc,
  output logic [1:0]        o_sel_a,
  output logic              o_sel_b,
  output logic              o_op_code,
  output logic              o_is_hlt
);

  // Decode-phase read strobe and halt detection, exec-phase datapath controls.
  always_comb begin
    o_rd_ram  = i_decode & reads_mem(i_opc_dec);
    o_is_hlt  = (i_opc_dec == OPC_HLT);
    o_wr_ram  = 1'b0;
    o_wr_acc  = 1'b0;
    o_sel_a   = SEL_A_MEM;
    o_sel_b   = 1'b0;
    o_op_code = 1'b0;
    if (i_exec) begin
      unique case (i_opc_ex)
        OPC_STO:  o_wr_ram = 1'b1;
        OPC_LD:   begin o_sel_a = SEL_A_MEM; o_wr_acc = 1'b1; end
        OPC_LDI:  begin o_sel_a = SEL_A_IMM; o_wr_acc = 1'b1; end
        OPC_ADD:  begin o_sel_a = SEL_A_ALU; o_op_code = 1'b1; o_wr_acc = 1'b1; end
        OPC_ADDI: begin o_sel_a = SEL_A_ALU; o_sel_b = 1'b1; o_op_code = 1'b1; o_wr_acc = 1'b1; end
        OPC_SUB:  begin o_sel_a = SEL_A_ALU; o_wr_acc = 1'b1; end
        OPC_SUBI: begin o_sel_a = SEL_A_ALU; o_sel_b = 1'b1; o_wr_acc = 1'b1; end
        default:  ; // HLT never reaches EXEC; unknown opcodes run as NOP
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: FETCH/DECODE/EXEC sequencer with PC, IR and a
// saturating executed-cycle counter. Control decode lives in bip_decoder.
module bip_control
  import bip_pkg::*;
#(
  parameter int NB_BITS = 16,
  parameter int NB_OPC  = 5,
  parameter int NB_ADDR = 11,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_instr,
  output logic [NB_ADDR-1:0] o_addr_pm,
  output logic [NB_ADDR-1:0] o_addr_dm,
  output logic               o_rd_ram,
  output logic               o_wr_ram,
  output logic [NB_ADDR-1:0] o_data_ins,
  output logic [1:0]         o_sel_a,
  output logic               o_sel_b,
  output logic               o_op_code,
  output logic               o_wr_acc,
  output logic               o_halt,
  output logic [NB_CNT-1:0]  o_cycles
);

  localparam logic [NB_ADDR-1:0] PC_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_CNT-1:0]  CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [NB_ADDR-1:0] pc;
  logic [NB_BITS-1:0] ir;
  logic [NB_CNT-1:0]  cnt;
  logic               is_hlt;
  logic               busy;

  assign busy = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: three cycles per instruction, HLT diverts from DECODE
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (i_start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = is_hlt ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // PC advances at the end of EXEC, IR latches the word seen in DECODE
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (state == ST_EXEC)   pc <= pc + PC_ONE;
      if (state == ST_DECODE) ir <= i_instr;
    end
  end

  // Executed-cycle counter, saturating at all-ones
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                 cnt <= '0;
    else if (busy && cnt != '1) cnt <= cnt + CNT_ONE;
  end

  bip_decoder #(.NB_OPC(NB_OPC)) u_dec (
    .i_decode  (state == ST_DECODE),
    .i_exec    (state == ST_EXEC),
    .i_opc_dec (i_instr[NB_BITS-1 -: NB_OPC]),
    .i_opc_ex  (ir[NB_BITS-1 -: NB_OPC]),
    .o_rd_ram  (o_rd_ram),
    .o_wr_ram  (o_wr_ram),
    .o_wr_acc  (o_wr_acc),
    .o_sel_a   (o_sel_a),
    .o_sel_b   (o_sel_b),
    .o_op_code (o_op_code),
    .o_is_hlt  (is_hlt)
  );

  // Data address comes from the live word in DECODE (read lead time), else IR
  always_comb begin
    o_addr_dm = ir[NB_ADDR-1:0];
    if (state == ST_DECODE) o_addr_dm = i_instr[NB_ADDR-1:0];
  end

  assign o_addr_pm  = pc;
  assign o_data_ins = ir[NB_ADDR-1:0];
  assign o_halt     = (state == ST_HALT);
  assign o_cycles   = cnt;

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: stimulus pushes expected control pulses,
// a negedge monitor pops and compares each pulse the DUT emits.
module tb_bip_control;

  logic        i_clk, i_rst, i_start;
  logic [15:0] i_instr;
  logic [10:0] o_addr_pm, o_addr_dm, o_data_ins;
  logic        o_rd_ram, o_wr_ram, o_sel_b, o_op_code, o_wr_acc, o_halt;
  logic [1:0]  o_sel_a;
  logic [31:0] o_cycles;

  logic [15:0] pm [2048];

  typedef struct packed {
    logic        rd;
    logic        wr_ram;
    logic        wr_acc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic [10:0] addr;
    logic [10:0] data;
  } ev_t;

  ev_t q[$];
  ev_t m_act, m_exp;
  int  n_cmp = 0;
  int  n_err = 0;

  bip_control #(.NB_BITS(16), .NB_OPC(5), .NB_ADDR(11), .NB_CNT(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_instr(i_instr),
    .o_addr_pm(o_addr_pm), .o_addr_dm(o_addr_dm), .o_rd_ram(o_rd_ram),
    .o_wr_ram(o_wr_ram), .o_data_ins(o_data_ins), .o_sel_a(o_sel_a),
    .o_sel_b(o_sel_b), .o_op_code(o_op_code), .o_wr_acc(o_wr_acc),
    .o_halt(o_halt), .o_cycles(o_cycles)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous program memory: data valid one cycle after the address
  always @(posedge i_clk) i_instr <= pm[o_addr_pm];

  function automatic ev_t mk(input logic rd, wr_ram, wr_acc, input logic [1:0] sel_a,
                             input logic sel_b, op, input logic [10:0] addr, data);
    ev_t e;
    e.rd = rd; e.wr_ram = wr_ram; e.wr_acc = wr_acc; e.sel_a = sel_a;
    e.sel_b = sel_b; e.op = op; e.addr = addr; e.data = data;
    return e;
  endfunction

  // Monitor: every enable pulse must match the next expected event
  always @(negedge i_clk) begin
    if (i_rst && (o_rd_ram || o_wr_ram || o_wr_acc)) begin
      m_act = mk(o_rd_ram, o_wr_ram, o_wr_acc, o_sel_a, o_sel_b, o_op_code,
                 o_addr_dm, o_data_ins);
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL pulse_unexpected: got %h, none expected (t=%0t)", m_act, $time);
      end else begin
        m_exp = q.pop_front();
        // operand bus is only meaningful on exec-phase pulses
        if (m_exp.rd) m_act.data = m_exp.data;
        if (m_act !== m_exp) begin
          n_err++;
          $display("FAIL pulse: got %h, expected %h (t=%0t)", m_act, m_exp, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_pm(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) pm[i] = w;
  endtask

  task automatic hold_reset();
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic release_and_start();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (o_halt) break;
      @(negedge i_clk);
    end
    chk({name, "_halt"}, o_halt, 1);
  endtask

  initial begin
    i_rst = 1'b0; i_start = 1'b0;
    clear_pm(16'h0000);
    #12;
    chk("rst_pc", o_addr_pm, 0);
    chk("rst_cycles", o_cycles, 0);
    chk("rst_halt", o_halt, 0);
    chk("rst_enables", {o_rd_ram, o_wr_ram, o_wr_acc, o_sel_a, o_sel_b, o_op_code}, 0);

    // Idle without i_start: nothing moves
    @(negedge i_clk); i_rst = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("idle_cycles", o_cycles, 0);
    chk("idle_pc", o_addr_pm, 0);

    // LDI 5; HLT
    hold_reset();
    pm[0] = 16'h1805; pm[1] = 16'h0000;
    q.push_back(mk(0, 0, 1, 2'b01, 0, 0, 11'd5, 11'd5));
    release_and_start();
    wait_halt("ldi", 40);
    chk("ldi_cycles", o_cycles, 5);
    chk("ldi_pc", o_addr_pm, 1);
    chk("ldi_drained", q.size(), 0);

    // i_start held in HALT: stays halted, counter frozen
    i_start = 1'b1;
    repeat (5) @(negedge i_clk);
    i_start = 1'b0;
    chk("hold_halt", o_halt, 1);
    chk("hold_cycles", o_cycles, 5);

    // LD 3; ADDI 0x7FF; STO 4; HLT
    hold_reset();
    clear_pm(16'h0000);
    pm[0] = 16'h1003; pm[1] = 16'h2FFF; pm[2] = 16'h0804; pm[3] = 16'h0000;
    q.push_back(mk(1, 0, 0, 2'b00, 0, 0, 11'd3, 11'd0));
    q.push_back(mk(0, 0, 1, 2'b00, 0, 0, 11'd3, 11'd3));
    q.push_back(mk(0, 0, 1, 2'b10, 1, 1, 11'h7FF, 11'h7FF));
    q.push_back(mk(0, 1, 0, 2'b00, 0, 0, 11'd4, 11'd4));
    release_and_start();
    wait_halt("prog2", 60);
    chk("prog2_cycles", o_cycles, 11);
    chk("prog2_pc", o_addr_pm, 3);
    chk("prog2_drained", q.size(), 0);

    // ADD 7; SUB 2; SUBI 1; HLT
    hold_reset();
    clear_pm(16'h0000);
    pm[0] = 16'h2007; pm[1] = 16'h3002; pm[2] = 16'h3801; pm[3] = 16'h0000;
    q.push_back(mk(1, 0, 0, 2'b00, 0, 0, 11'd7, 11'd0));
    q.push_back(mk(0, 0, 1, 2'b10, 0, 1, 11'd7, 11'd7));
    q.push_back(mk(1, 0, 0, 2'b00, 0, 0, 11'd2, 11'd0));
    q.push_back(mk(0, 0, 1, 2'b10, 0, 0, 11'd2, 11'd2));
    q.push_back(mk(0, 0, 1, 2'b10, 1, 0, 11'd1, 11'd1));
    release_and_start();
    wait_halt("prog3", 60);
    chk("prog3_cycles", o_cycles, 11);
    chk("prog3_pc", o_addr_pm, 3);
    chk("prog3_drained", q.size(), 0);

    // Opcode 11111 everywhere: no pulses, PC walks to 2047 then wraps to 0
    hold_reset();
    clear_pm(16'hF805);
    release_and_start();
    for (int k = 0; k < 7000; k++) begin
      if (o_addr_pm == 11'd2047) break;
      @(negedge i_clk);
    end
    chk("nop_pc_top", o_addr_pm, 2047);
    for (int k = 0; k < 10; k++) begin
      if (o_addr_pm == 11'd0) break;
      @(negedge i_clk);
    end
    chk("nop_pc_wrap", o_addr_pm, 0);
    chk("nop_cycles", o_cycles, 6144);
    chk("nop_halt", o_halt, 0);

    // Reset during STO exec: write strobe drops at once, restart needs i_start
    hold_reset();
    clear_pm(16'h0000);
    pm[0] = 16'h0804;
    q.push_back(mk(0, 1, 0, 2'b00, 0, 0, 11'd4, 11'd4));
    release_and_start();
    for (int k = 0; k < 20; k++) begin
      if (o_wr_ram) break;
      @(negedge i_clk);
    end
    chk("sto_seen", o_wr_ram, 1);
    #2 i_rst = 1'b0;
    #1;
    chk("abort_wr_ram", o_wr_ram, 0);
    chk("abort_pc", o_addr_pm, 0);
    chk("abort_cycles", o_cycles, 0);
    @(negedge i_clk); i_rst = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("abort_idle_cycles", o_cycles, 0);
    chk("abort_idle_halt", o_halt, 0);
    q.push_back(mk(0, 1, 0, 2'b00, 0, 0, 11'd4, 11'd4));
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    wait_halt("rerun", 40);
    chk("rerun_cycles", o_cycles, 5);
    chk("rerun_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
